ysyx_22041207_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_22041207_hazard_ctrl

Overview:
Pipeline control unit that drives the stall (bubble) and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also produces the ID-stage operand-forwarding selects.
It resolves four hazard classes:
- load-use data hazards;
- control redirects resolved in EX (branch, jal, jalr, trap, mret);
- CSR serialization, which drains older instructions before a CSR instruction leaves ID;
- data-memory wait states.

Parameters:
REG_AW, 5, register address width
CSR_DRAIN_CYCLES, 3, cycles ID/EX is held empty behind a CSR instruction (1..7)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1addr  in  REG_AW  ID source 1
id_rs2addr  in  REG_AW  ID source 2
id_use_rs1  in  1  ID reads rs1
id_use_rs2  in  1  ID reads rs2
id_csr  in  1  ID instruction is CSR/ecall/mret
ex_valid  in  1  EX holds a real instruction
ex_rwaddr  in  REG_AW  EX destination register
ex_writeRD  in  1  EX writes its destination register
ex_memoryReadWen  in  1  EX instruction is a load
mem_valid  in  1  MEM holds a real instruction
mem_rwaddr  in  REG_AW  MEM destination register
mem_writeRD  in  1  MEM writes its destination register
wb_valid  in  1  WB holds a real instruction
wb_rwaddr  in  REG_AW  WB destination register
wb_writeRD  in  1  WB writes its destination register
ex_redirect  in  1  EX resolved a taken branch/jump/trap/mret
dmem_req  in  1  MEM issuing a data access
dmem_ready  in  1  data memory completes this cycle
pc_stall  out  1  hold PC
ifid_bubble  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID
idex_bubble  out  1  hold ID/EX
idex_flush  out  1  clear ID/EX
exmem_bubble  out  1  hold EX/MEM
memwb_flush  out  1  insert NOP into MEM/WB
fwd_a_sel  out  2  rs1 source: 0 regfile, 1 EX, 2 MEM, 3 WB
fwd_b_sel  out  2  rs2 source (same encoding)
hz_state  out  2  current FSM state (debug)

Behaviour:
Structure
- FSM states: RUN=0, MEM_WAIT=1, CSR_DRAIN=2. A 3-bit drain counter `cnt` accompanies the FSM.
- All outputs are combinational from state and inputs, valid in the same cycle.
- "Match" means: producer valid, producer writeRD=1, rwaddr==source, rwaddr!=0, and the ID source is used.
- x0 never causes a hazard.

Reset
- While rst_n=0: ifid_flush, idex_flush and memwb_flush are 1. All other outputs are 0; hz_state=RUN.
- On the next edge the FSM is set to RUN and cnt=0. Reset asserted mid-wait or mid-drain aborts to RUN.

Priority (highest first): reset > MEM_WAIT > ex_redirect > CSR drain > data hazard.

MEM_WAIT
- Entered from RUN or CSR_DRAIN when dmem_req=1 and dmem_ready=0.
- In MEM_WAIT: pc_stall, ifid_bubble, idex_bubble and exmem_bubble are 1; memwb_flush=1.
- Returns to RUN on the edge where dmem_ready=1; that cycle already releases all stalls.
- An ex_redirect seen during MEM_WAIT is not acted on. EX is held, so the redirect is re-presented and honoured after the wait.
- cnt is preserved; if cnt>0 the FSM resumes CSR_DRAIN instead of RUN.

Redirect (RUN or CSR_DRAIN)
- ifid_flush=1 and idex_flush=1; pc_stall=0 so the target PC loads.
- Overrides a load-use stall and a CSR drain. The drain is aborted: cnt=0, FSM to RUN.

CSR drain
- In RUN, when id_valid and id_csr with no redirect: load cnt=CSR_DRAIN_CYCLES and enter CSR_DRAIN.
- In CSR_DRAIN: pc_stall=1, ifid_bubble=1, idex_flush=1; cnt decrements each edge.
- At cnt==1 the FSM returns to RUN with the CSR instruction released into EX; no re-trigger that cycle.
- Total hold is CSR_DRAIN_CYCLES cycles.

Load-use (RUN only)
- Condition: EX is a load (ex_memoryReadWen=1) and it matches an ID source.
- Response for exactly one cycle: pc_stall=1, ifid_bubble=1, idex_flush=1. No state change.

Forward selects
- Priority EX > MEM > WB per operand; 0 when there is no match.
- An EX-stage load never produces sel=1; the load-use stall covers it.

Optional Feature:
YSYX_22041207_FORWARD_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined: fwd_a_sel and fwd_b_sel are tied to 0. Any match against EX, MEM or WB produces the same one-cycle stall response as load-use, re-evaluated every cycle until no match remains.

Decomposition:
- Shared package: state encodings, fwd_sel encodings, REG_AW default.
- One sub-module, ysyx_22041207_hazard_match: combinational match and priority-encode per source operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset, then release: with rst_n=0 all flush outputs are 1. One cycle after release, every output is 0 and hz_state=0.
- Load-use: EX load with rd=5, ID rs1=5 → one cycle of pc_stall, ifid_bubble and idex_flush. Next cycle fwd_a_sel=2.
- x0 and forwarding: EX rd=0 with ID rs1=0 → no stall and fwd_a_sel=0. EX add rd=7, MEM rd=7 → fwd_b_sel=1.
- CSR drain: id_csr=1 with CSR_DRAIN_CYCLES=3 → exactly 3 stalled cycles, then release. A redirect arriving in cycle 2 aborts: both flush outputs are 1 and the FSM returns to RUN.
- Memory wait: dmem_req=1 with dmem_ready=0 for 4 cycles → 4 cycles of full stall plus memwb_flush. A concurrent ex_redirect is honoured on the cycle after dmem_ready.
- Macro off: add rd=3 in WB with ID rs2=3 → stall is asserted and fwd_b_sel=0.

Source files
------------

// File: rtl/ysyx_22041207_hazard_ctrl_pkg.sv
// Shared encodings for the hazard control slice: FSM states, forward-select codes,
// default register-address width and the CSR drain counter width.
package ysyx_22041207_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_CSR_DRAIN = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

endpackage

// File: rtl/ysyx_22041207_hazard_ctrl_if.sv
// Pipeline <-> hazard control bundle. The pipeline side (master) reports stage contents
// and memory status; the hazard unit (slave) returns stall/flush controls and forward selects.
interface ysyx_22041207_hazard_ctrl_if
    import ysyx_22041207_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1addr;
    logic [REG_AW-1:0] id_rs2addr;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_csr;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rwaddr;
    logic              ex_writeRD;
    logic              ex_memoryReadWen;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rwaddr;
    logic              mem_writeRD;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rwaddr;
    logic              wb_writeRD;
    logic              ex_redirect;
    logic              dmem_req;
    logic              dmem_ready;
    logic              pc_stall;
    logic              ifid_bubble;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              idex_flush;
    logic              exmem_bubble;
    logic              memwb_flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [1:0]        hz_state;

    modport master (
        output id_valid, id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2, id_csr,
        output ex_valid, ex_rwaddr, ex_writeRD, ex_memoryReadWen,
        output mem_valid, mem_rwaddr, mem_writeRD,
        output wb_valid, wb_rwaddr, wb_writeRD,
        output ex_redirect, dmem_req, dmem_ready,
        input  pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush,
        input  exmem_bubble, memwb_flush, fwd_a_sel, fwd_b_sel, hz_state
    );

    modport slave (
        input  id_valid, id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2, id_csr,
        input  ex_valid, ex_rwaddr, ex_writeRD, ex_memoryReadWen,
        input  mem_valid, mem_rwaddr, mem_writeRD,
        input  wb_valid, wb_rwaddr, wb_writeRD,
        input  ex_redirect, dmem_req, dmem_ready,
        output pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush,
        output exmem_bubble, memwb_flush, fwd_a_sel, fwd_b_sel, hz_state
    );

endinterface

// File: rtl/ysyx_22041207_hazard_match.sv
// Per-operand producer match against EX/MEM/WB with youngest-first forward select.
// x0 and unused sources never match.
module ysyx_22041207_hazard_match
    import ysyx_22041207_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rwaddr,
    input  logic              ex_write_rd,
    input  logic              ex_load,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rwaddr,
    input  logic              mem_write_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rwaddr,
    input  logic              wb_write_rd,
    output fwd_sel_t          fwd_sel,
    output logic              any_hit,
    output logic              load_hit
);
    logic live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign live     = used && (src != '0);
    assign ex_hit   = live && ex_valid  && ex_write_rd  && (ex_rwaddr  == src);
    assign mem_hit  = live && mem_valid && mem_write_rd && (mem_rwaddr == src);
    assign wb_hit   = live && wb_valid  && wb_write_rd  && (wb_rwaddr  == src);
    assign any_hit  = ex_hit || mem_hit || wb_hit;
    assign load_hit = ex_hit && ex_load;

    // A load in EX is the youngest producer but has no data yet, so it blocks the
    // older stages from being selected; the load-use stall resolves it.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_hit) begin
            fwd_sel = ex_load ? FWD_RF : FWD_EX;
        end else if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// Pipeline hazard control: memory wait, EX redirect, CSR drain and data-hazard stalls.
// Define YSYX_22041207_FORWARD_EN to enable ID operand forwarding; otherwise any match stalls.
module ysyx_22041207_hazard_ctrl
    import ysyx_22041207_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW           = REG_AW_DEF,
    parameter int CSR_DRAIN_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_22041207_hazard_ctrl_if.slave    bus
);
`ifdef YSYX_22041207_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(CSR_DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    hz_state_t        state;
    hz_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    fwd_sel_t         sel_a;
    fwd_sel_t         sel_b;
    logic             hit_a;
    logic             hit_b;
    logic             load_a;
    logic             load_b;
    logic             mem_wait;
    logic             data_hazard;
    logic             csr_start;
    logic             full_stall;
    logic             hold_id;
    logic             redirect_flush;

    ysyx_22041207_hazard_match #(.REG_AW(REG_AW)) u_match_a (
        .src          (bus.id_rs1addr),
        .used         (bus.id_use_rs1),
        .ex_valid     (bus.ex_valid),
        .ex_rwaddr    (bus.ex_rwaddr),
        .ex_write_rd  (bus.ex_writeRD),
        .ex_load      (bus.ex_memoryReadWen),
        .mem_valid    (bus.mem_valid),
        .mem_rwaddr   (bus.mem_rwaddr),
        .mem_write_rd (bus.mem_writeRD),
        .wb_valid     (bus.wb_valid),
        .wb_rwaddr    (bus.wb_rwaddr),
        .wb_write_rd  (bus.wb_writeRD),
        .fwd_sel      (sel_a),
        .any_hit      (hit_a),
        .load_hit     (load_a)
    );

    ysyx_22041207_hazard_match #(.REG_AW(REG_AW)) u_match_b (
        .src          (bus.id_rs2addr),
        .used         (bus.id_use_rs2),
        .ex_valid     (bus.ex_valid),
        .ex_rwaddr    (bus.ex_rwaddr),
        .ex_write_rd  (bus.ex_writeRD),
        .ex_load      (bus.ex_memoryReadWen),
        .mem_valid    (bus.mem_valid),
        .mem_rwaddr   (bus.mem_rwaddr),
        .mem_write_rd (bus.mem_writeRD),
        .wb_valid     (bus.wb_valid),
        .wb_rwaddr    (bus.wb_rwaddr),
        .wb_write_rd  (bus.wb_writeRD),
        .fwd_sel      (sel_b),
        .any_hit      (hit_b),
        .load_hit     (load_b)
    );

    assign mem_wait    = bus.dmem_req && !bus.dmem_ready;
    assign data_hazard = FWD_EN ? (load_a || load_b) : (hit_a || hit_b);
    assign csr_start   = bus.id_valid && bus.id_csr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // cnt is left untouched across a memory wait so the drain resumes where it stopped.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nx = ST_MEM_WAIT;
                end else if (bus.ex_redirect) begin
                    cnt_nx = '0;
                end else if (csr_start) begin
                    state_nx = ST_CSR_DRAIN;
                    cnt_nx   = DRAIN_LOAD;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_nx = (cnt != '0) ? ST_CSR_DRAIN : ST_RUN;
                end
            end
            ST_CSR_DRAIN: begin
                if (mem_wait) begin
                    state_nx = ST_MEM_WAIT;
                end else if (bus.ex_redirect || cnt <= CNT_ONE) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // The cnt==1 drain cycle releases the CSR into EX; it only stalls for a live data hazard.
    always_comb begin
        full_stall     = 1'b0;
        hold_id        = 1'b0;
        redirect_flush = 1'b0;
        if (state == ST_MEM_WAIT) begin
            if (!bus.dmem_ready) begin
                full_stall = 1'b1;
            end else if (cnt != '0) begin
                hold_id = 1'b1;
            end
        end else if (mem_wait) begin
            full_stall = 1'b1;
        end else if (bus.ex_redirect) begin
            redirect_flush = 1'b1;
        end else if ((state == ST_RUN && csr_start) ||
                     (state == ST_CSR_DRAIN && cnt > CNT_ONE) ||
                     data_hazard) begin
            hold_id = 1'b1;
        end
    end

    assign bus.pc_stall     = rst_n && (full_stall || hold_id);
    assign bus.ifid_bubble  = rst_n && (full_stall || hold_id);
    assign bus.ifid_flush   = !rst_n || redirect_flush;
    assign bus.idex_bubble  = rst_n && full_stall;
    assign bus.idex_flush   = !rst_n || redirect_flush || hold_id;
    assign bus.exmem_bubble = rst_n && full_stall;
    assign bus.memwb_flush  = !rst_n || full_stall;
    assign bus.fwd_a_sel    = (rst_n && FWD_EN) ? sel_a : FWD_RF;
    assign bus.fwd_b_sel    = (rst_n && FWD_EN) ? sel_b : FWD_RF;
    assign bus.hz_state     = rst_n ? state : ST_RUN;

endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// Directed bench for ysyx_22041207_hazard_ctrl; expectations follow YSYX_22041207_FORWARD_EN.
module tb_ysyx_22041207_hazard_ctrl;

`ifdef YSYX_22041207_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // control vector: {pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush, exmem_bubble, memwb_flush}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b0010101;
    localparam logic [6:0] C_HAZ   = 7'b1100100;
    localparam logic [6:0] C_REDIR = 7'b0010100;
    localparam logic [6:0] C_MEMW  = 7'b1101011;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MEMW  = 2'd1;
    localparam logic [1:0] S_CSR   = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ysyx_22041207_hazard_ctrl_if #(.REG_AW(5)) bus ();

    ysyx_22041207_hazard_ctrl #(.REG_AW(5), .CSR_DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {bus.pc_stall, bus.ifid_bubble, bus.ifid_flush, bus.idex_bubble,
                bus.idex_flush, bus.exmem_bubble, bus.memwb_flush};
    endfunction

    task automatic check_ctl(input string tag, input logic [6:0] e_ctl, input logic [1:0] e_st);
        chk({tag, ".ctl"}, 32'(ctl()), 32'(e_ctl));
        chk({tag, ".st"},  32'(bus.hz_state), 32'(e_st));
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] e_a, input logic [1:0] e_b);
        chk({tag, ".fa"}, 32'(bus.fwd_a_sel), 32'(e_a));
        chk({tag, ".fb"}, 32'(bus.fwd_b_sel), 32'(e_b));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic csr);
        bus.id_valid = v; bus.id_rs1addr = rs1; bus.id_rs2addr = rs2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_csr = csr;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic wr, input logic ld);
        bus.ex_valid = v; bus.ex_rwaddr = rd; bus.ex_writeRD = wr; bus.ex_memoryReadWen = ld;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic wr);
        bus.mem_valid = v; bus.mem_rwaddr = rd; bus.mem_writeRD = wr;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic wr);
        bus.wb_valid = v; bus.wb_rwaddr = rd; bus.wb_writeRD = wr;
    endtask

    task automatic clear_in();
        set_id(0, 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0);
        set_wb(0, 0, 0);
        bus.ex_redirect = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
    endtask

    initial begin
        // reset with busy inputs: flushes only, forwards held at 0
        rst_n = 1'b0;
        clear_in();
        set_id(1, 0, 7, 0, 1, 1);
        set_ex(1, 7, 1, 0);
        bus.dmem_req = 1; bus.ex_redirect = 1;
        repeat (2) @(posedge clk);
        #2;
        check_ctl("rst", C_RST, S_RUN);
        check_fwd("rst", 2'd0, 2'd0);

        cyc(); rst_n = 1'b1; clear_in(); #1;
        check_ctl("rel0", C_NONE, S_RUN);
        cyc(); #1;
        check_ctl("rel1", C_NONE, S_RUN);
        check_fwd("rel1", 2'd0, 2'd0);

        // load-use on rs1 = x5
        cyc(); set_ex(1, 5, 1, 1); set_id(1, 5, 0, 1, 0, 0); #1;
        check_ctl("lu", C_HAZ, S_RUN);
        cyc(); set_ex(0, 0, 0, 0); set_mem(1, 5, 1); #1;
        check_ctl("lu_mem", FWD_ON ? C_NONE : C_HAZ, S_RUN);
        check_fwd("lu_mem", FWD_ON ? 2'd2 : 2'd0, 2'd0);
        cyc(); set_mem(0, 0, 0); set_wb(1, 5, 1); #1;
        check_ctl("lu_wb", FWD_ON ? C_NONE : C_HAZ, S_RUN);
        check_fwd("lu_wb", FWD_ON ? 2'd3 : 2'd0, 2'd0);

        // x0 never matches, even as a load destination
        cyc(); clear_in(); set_ex(1, 0, 1, 1); set_id(1, 0, 0, 1, 1, 0); #1;
        check_ctl("x0", C_NONE, S_RUN);
        check_fwd("x0", 2'd0, 2'd0);
        // source not read
        cyc(); set_ex(1, 6, 1, 1); set_id(1, 6, 6, 0, 0, 0); #1;
        check_ctl("unused", C_NONE, S_RUN);

        // EX beats MEM for rs2 = x7
        cyc(); clear_in(); set_ex(1, 7, 1, 0); set_mem(1, 7, 1); set_id(1, 0, 7, 0, 1, 0); #1;
        check_ctl("exmem", FWD_ON ? C_NONE : C_HAZ, S_RUN);
        check_fwd("exmem", 2'd0, FWD_ON ? 2'd1 : 2'd0);
        cyc(); set_ex(1, 7, 0, 0); #1;
        check_fwd("nowr", 2'd0, FWD_ON ? 2'd2 : 2'd0);

        // WB producer rs2 = x3
        cyc(); clear_in(); set_wb(1, 3, 1); set_id(1, 0, 3, 0, 1, 0); #1;
        check_ctl("wb", FWD_ON ? C_NONE : C_HAZ, S_RUN);
        check_fwd("wb", 2'd0, FWD_ON ? 2'd3 : 2'd0);

        // CSR drain, 3 held cycles then release without re-trigger
        cyc(); clear_in(); set_id(1, 0, 0, 0, 0, 1); #1;
        check_ctl("csr0", C_HAZ, S_RUN);
        cyc(); #1; check_ctl("csr1", C_HAZ, S_CSR);
        cyc(); #1; check_ctl("csr2", C_HAZ, S_CSR);
        cyc(); #1; check_ctl("csr3", C_NONE, S_CSR);
        cyc(); set_id(1, 0, 0, 0, 0, 0); #1;
        check_ctl("csr4", C_NONE, S_RUN);

        // redirect in drain cycle 2 aborts
        cyc(); clear_in(); set_id(1, 0, 0, 0, 0, 1); #1;
        check_ctl("ab0", C_HAZ, S_RUN);
        cyc(); #1; check_ctl("ab1", C_HAZ, S_CSR);
        cyc(); bus.ex_redirect = 1; #1;
        check_ctl("ab2", C_REDIR, S_CSR);
        cyc(); clear_in(); #1;
        check_ctl("ab3", C_NONE, S_RUN);

        // 4 cycles of memory wait with a pending redirect
        cyc(); clear_in(); bus.dmem_req = 1; bus.ex_redirect = 1; #1;
        check_ctl("mw0", C_MEMW, S_RUN);
        for (int i = 1; i < 4; i++) begin
            cyc(); #1;
            check_ctl($sformatf("mw%0d", i), C_MEMW, S_MEMW);
        end
        cyc(); bus.dmem_ready = 1; #1;
        check_ctl("mw_rdy", C_NONE, S_MEMW);
        cyc(); bus.dmem_req = 0; bus.dmem_ready = 0; #1;
        check_ctl("mw_redir", C_REDIR, S_RUN);
        cyc(); clear_in(); #1;
        check_ctl("mw_end", C_NONE, S_RUN);

        // memory wait inside a drain keeps the remaining count
        cyc(); set_id(1, 0, 0, 0, 0, 1); #1;
        check_ctl("dw0", C_HAZ, S_RUN);
        cyc(); bus.dmem_req = 1; #1;
        check_ctl("dw1", C_MEMW, S_CSR);
        cyc(); #1;
        check_ctl("dw2", C_MEMW, S_MEMW);
        cyc(); bus.dmem_ready = 1; #1;
        chk("dw3.st", 32'(bus.hz_state), 32'(S_MEMW));
        cyc(); bus.dmem_req = 0; bus.dmem_ready = 0; #1;
        check_ctl("dw4", C_HAZ, S_CSR);
        cyc(); #1; check_ctl("dw5", C_HAZ, S_CSR);
        cyc(); #1; check_ctl("dw6", C_NONE, S_CSR);
        cyc(); set_id(0, 0, 0, 0, 0, 0); #1;
        check_ctl("dw7", C_NONE, S_RUN);

        // reset mid-drain
        cyc(); set_id(1, 0, 0, 0, 0, 1); #1;
        check_ctl("rd0", C_HAZ, S_RUN);
        cyc(); rst_n = 1'b0; #1;
        check_ctl("rd1", C_RST, S_RUN);
        cyc(); rst_n = 1'b1; clear_in(); #1;
        check_ctl("rd2", C_NONE, S_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
